// File: rtl/tree_sum_pkg.sv
// Shared types and constants for the tree-sum frame accumulator.
// Contents:
//   state_e        accumulator FSM states
//   Default*W      default widths for the tree-sum input, the accumulator and the count fields
//   sat_max/min    most positive / most negative value of a w-bit signed number, returned
//                  zero-extended to 64 bits; the caller truncates the result to w bits
package tree_sum_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StHold
  } state_e;

  localparam int unsigned DefaultInW  = 16;
  localparam int unsigned DefaultAccW = 24;
  localparam int unsigned DefaultCntW = 8;

  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Keeping only the low w bits leaves 100..0, the most negative w-bit value.
  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/sum_sat_add.sv
// Combinational ACC_W-bit signed adder with a signed-overflow flag.
// Build option: define ACC_SATURATE_EN to clip an overflowing result to the most positive or
// most negative value. Without it, the result wraps in two's complement. The overflow flag is
// reported in both builds.
// Ports:
//   a_i    in   ACC_W  signed augend (running accumulator)
//   b_i    in   ACC_W  signed addend (sign-extended tree sum)
//   sum_o  out  ACC_W  signed result (wrapped or clipped)
//   ovf_o  out  1      signed overflow occurred on this add
module sum_sat_add
  import tree_sum_pkg::*;
#(
  parameter int unsigned ACC_W = DefaultAccW
) (
  input  logic signed [ACC_W-1:0] a_i,
  input  logic signed [ACC_W-1:0] b_i,
  output logic signed [ACC_W-1:0] sum_o,
  output logic                    ovf_o
);

`ifdef ACC_SATURATE_EN
  localparam logic [ACC_W-1:0] MaxVal = ACC_W'(sat_max(ACC_W));
  localparam logic [ACC_W-1:0] MinVal = ACC_W'(sat_min(ACC_W));
`endif

  logic signed [ACC_W-1:0] raw;

  always_comb begin
    raw   = a_i + b_i;
    // Overflow is only possible when both operands have the same sign.
    ovf_o = (a_i[ACC_W-1] == b_i[ACC_W-1]) && (raw[ACC_W-1] != a_i[ACC_W-1]);
`ifdef ACC_SATURATE_EN
    if (ovf_o) begin
      // The operands share a sign, so a's sign gives the direction to clip.
      sum_o = a_i[ACC_W-1] ? MinVal : MaxVal;
    end else begin
      sum_o = raw;
    end
`else
    sum_o = raw;
`endif
  end

endmodule

// File: rtl/tree_sum_accumulator.sv
// Accumulates frame_len consecutive adder-tree sums into one signed frame total. The total is
// presented with a valid/ready handshake and held until the consumer accepts it.
// Build option: ACC_SATURATE_EN selects a saturating accumulator (see sum_sat_add).
// Ports:
//   clk_i        in   1      system clock, rising edge
//   rst_i        in   1      asynchronous, active-high reset
//   start_i      in   1      begin a frame (honoured only in IDLE)
//   frame_len_i  in   CNT_W  sums per frame, sampled with start_i; 0 is treated as 1
//   in_valid_i   in   1      in_sum_i carries a valid tree sum
//   in_sum_i     in   IN_W   signed tree sum
//   in_ready_o   out  1      in_sum_i is accepted this cycle
//   out_valid_o  out  1      frame total is valid
//   out_ready_i  in   1      consumer accepts the total
//   out_sum_o    out  ACC_W  signed frame total
//   out_count_o  out  CNT_W  number of sums in the presented total
//   busy_o       out  1      a frame is in progress or being presented
//   overflow_o   out  1      sticky per frame: an add overflowed or was clipped
module tree_sum_accumulator
  import tree_sum_pkg::*;
#(
  parameter int unsigned IN_W  = DefaultInW,
  parameter int unsigned ACC_W = DefaultAccW,
  parameter int unsigned CNT_W = DefaultCntW
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        frame_len_i,
  input  logic                    in_valid_i,
  input  logic signed [IN_W-1:0]  in_sum_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [ACC_W-1:0] out_sum_o,
  output logic [CNT_W-1:0]        out_count_o,
  output logic                    busy_o,
  output logic                    overflow_o
);

  state_e state_q, state_d;

  logic [CNT_W-1:0]        len_q, len_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic signed [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0]        out_count_q, out_count_d;

  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] add_sum;
  logic                    add_ovf;
  logic                    beat;
  logic [CNT_W-1:0]        cnt_inc;
  logic                    last_beat;

  // A size cast of a signed operand sign-extends it.
  assign in_ext    = ACC_W'(in_sum_i);
  assign beat      = in_valid_i && in_ready_o;
  assign cnt_inc   = cnt_q + CNT_W'(1);
  assign last_beat = beat && (cnt_inc == len_q);

  sum_sat_add #(
    .ACC_W (ACC_W)
  ) u_add (
    .a_i   (acc_q),
    .b_i   (in_ext),
    .sum_o (add_sum),
    .ovf_o (add_ovf)
  );

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start_i) state_d = StAccum;
      StAccum: if (last_beat) state_d = StHold;
      // start_i arriving with out_ready_i is ignored; the FSM always spends a cycle in IDLE.
      StHold:  if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs that depend only on the state.
  always_comb begin
    in_ready_o  = (state_q == StAccum);
    out_valid_o = (state_q == StHold);
    busy_o      = (state_q != StIdle);
  end

  // Datapath next-state logic.
  always_comb begin
    len_d       = len_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    if (state_q == StIdle && start_i) begin
      len_d = (frame_len_i == '0) ? CNT_W'(1) : frame_len_i;
      cnt_d = '0;
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (beat) begin
      acc_d = add_sum;
      cnt_d = cnt_inc;
      ovf_d = ovf_q | add_ovf;
      if (last_beat) begin
        out_sum_d   = add_sum;
        out_count_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_count_q <= '0;
    end else begin
      len_q       <= len_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
    end
  end

  assign out_sum_o   = out_sum_q;
  assign out_count_o = out_count_q;
  assign overflow_o  = ovf_q;

endmodule

// File: tb/tb_tree_sum_accumulator.sv
// Directed bench for tree_sum_accumulator. Instance a uses the default widths; instance b uses
// IN_W = ACC_W = 16 so that overflow can be reached.
module tb_tree_sum_accumulator;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Instance a: IN_W=16, ACC_W=24, CNT_W=8
  logic               a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic               a_busy, a_overflow;
  logic [7:0]         a_frame_len, a_out_count;
  logic signed [15:0] a_in_sum;
  logic signed [23:0] a_out_sum;

  // Instance b: IN_W=16, ACC_W=16, CNT_W=8
  logic               b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic               b_busy, b_overflow;
  logic [7:0]         b_frame_len, b_out_count;
  logic signed [15:0] b_in_sum;
  logic signed [15:0] b_out_sum;

`ifdef ACC_SATURATE_EN
  localparam int ExpPos = 32767;
  localparam int ExpNeg = -32767;
`else
  localparam int ExpPos = -32768;
  localparam int ExpNeg = -32768;
`endif

  tree_sum_accumulator u_dut_a (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (a_start),
    .frame_len_i (a_frame_len),
    .in_valid_i  (a_in_valid),
    .in_sum_i    (a_in_sum),
    .in_ready_o  (a_in_ready),
    .out_valid_o (a_out_valid),
    .out_ready_i (a_out_ready),
    .out_sum_o   (a_out_sum),
    .out_count_o (a_out_count),
    .busy_o      (a_busy),
    .overflow_o  (a_overflow)
  );

  tree_sum_accumulator #(
    .IN_W  (16),
    .ACC_W (16),
    .CNT_W (8)
  ) u_dut_b (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (b_start),
    .frame_len_i (b_frame_len),
    .in_valid_i  (b_in_valid),
    .in_sum_i    (b_in_sum),
    .in_ready_o  (b_in_ready),
    .out_valid_o (b_out_valid),
    .out_ready_i (b_out_ready),
    .out_sum_o   (b_out_sum),
    .out_count_o (b_out_count),
    .busy_o      (b_busy),
    .overflow_o  (b_overflow)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    a_start = 0; a_frame_len = 0; a_in_valid = 0; a_in_sum = 0; a_out_ready = 1;
    b_start = 0; b_frame_len = 0; b_in_valid = 0; b_in_sum = 0; b_out_ready = 1;
    tick();
    tick();
    check("rst_busy", a_busy, 0);
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_sum", a_out_sum, 0);
    check("rst_out_count", a_out_count, 0);
    check("rst_overflow", a_overflow, 0);
    rst = 1'b0;
    tick();

    // A tree sum offered while no frame is active must not be accepted.
    a_in_valid = 1; a_in_sum = 99;
    #1;
    check("idle_in_ready", a_in_ready, 0);
    a_in_valid = 0;
    tick();

    // Reset in the middle of a frame discards the partial sum.
    a_start = 1; a_frame_len = 4;
    tick();
    a_start = 0;
    check("mid_busy", a_busy, 1);
    check("mid_in_ready", a_in_ready, 1);
    a_in_valid = 1; a_in_sum = 10; tick();
    a_in_sum = 20; tick();
    a_in_valid = 0;
    rst = 1;
    #1;
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_in_ready", a_in_ready, 0);
    check("mid_rst_out_sum", a_out_sum, 0);
    check("mid_rst_out_count", a_out_count, 0);
    tick();
    rst = 0;
    a_in_valid = 1; a_in_sum = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("post_rst_no_valid", a_out_valid, 0);
    end
    a_in_valid = 0;

    // Basic frame: 10 - 3 + 7 + 1 = 15
    a_start = 1; a_frame_len = 4;
    tick();
    a_start = 0;
    a_in_valid = 1;
    a_in_sum = 10; tick();
    a_in_sum = -3; tick();
    a_in_sum = 7;  tick();
    a_in_sum = 1;
    check("basic_no_early_valid", a_out_valid, 0);
    tick();
    a_in_valid = 0;
    check("basic_out_valid", a_out_valid, 1);
    check("basic_out_sum", a_out_sum, 15);
    check("basic_out_count", a_out_count, 4);
    check("basic_overflow", a_overflow, 0);
    check("basic_hold_in_ready", a_in_ready, 0);
    tick();
    check("basic_done_valid", a_out_valid, 0);
    check("basic_done_busy", a_busy, 0);

    // Backpressure: 5 + 5 held while out_ready is low.
    a_out_ready = 0;
    a_start = 1; a_frame_len = 2;
    tick();
    a_start = 0;
    a_in_valid = 1; a_in_sum = 5; tick();
    tick();
    a_in_valid = 0;
    for (int i = 0; i < 6; i++) begin
      check("bp_out_valid", a_out_valid, 1);
      check("bp_out_sum", a_out_sum, 10);
      check("bp_in_ready", a_in_ready, 0);
      tick();
    end
    // A start that arrives together with the accepting out_ready is ignored.
    a_out_ready = 1; a_start = 1; a_frame_len = 5;
    tick();
    a_start = 0;
    check("bp_accept_valid", a_out_valid, 0);
    check("bp_start_ignored_busy", a_busy, 0);
    tick();

    // Gapped input; the frame_len change in mid-frame is ignored. 100 + 200 + 300 = 600
    a_start = 1; a_frame_len = 3;
    tick();
    a_start = 0; a_frame_len = 1;
    a_in_valid = 1; a_in_sum = 100; tick();
    a_in_valid = 0; a_in_sum = 7;   tick();
    a_in_valid = 1; a_in_sum = 200; tick();
    a_in_valid = 0;                 tick();
    check("gap_not_done", a_out_valid, 0);
    a_in_valid = 1; a_in_sum = 300; tick();
    a_in_valid = 0;
    check("gap_out_valid", a_out_valid, 1);
    check("gap_out_sum", a_out_sum, 600);
    check("gap_out_count", a_out_count, 3);
    tick();

    // frame_len 0 behaves as 1.
    a_start = 1; a_frame_len = 0;
    tick();
    a_start = 0;
    a_in_valid = 1; a_in_sum = -42; tick();
    a_in_valid = 0;
    check("len0_out_valid", a_out_valid, 1);
    check("len0_out_sum", a_out_sum, -42);
    check("len0_out_count", a_out_count, 1);
    tick();

    // Positive overflow on the 16-bit accumulator: 32767 + 1
    b_start = 1; b_frame_len = 2;
    tick();
    b_start = 0;
    b_in_valid = 1; b_in_sum = 16'sd32767; tick();
    b_in_sum = 16'sd1; tick();
    b_in_valid = 0;
    check("ovfp_out_valid", b_out_valid, 1);
    check("ovfp_out_sum", b_out_sum, ExpPos);
    check("ovfp_overflow", b_overflow, 1);
    tick();

    // Negative overflow and then an in-range add: -32768 - 1 + 1
    b_start = 1; b_frame_len = 3;
    tick();
    b_start = 0;
    b_in_valid = 1; b_in_sum = -16'sd32768; tick();
    b_in_sum = -16'sd1; tick();
    b_in_sum = 16'sd1;  tick();
    b_in_valid = 0;
    check("ovfn_out_sum", b_out_sum, ExpNeg);
    check("ovfn_out_count", b_out_count, 3);
    check("ovfn_overflow", b_overflow, 1);
    tick();

    // The sticky overflow flag is cleared by the next start.
    b_start = 1; b_frame_len = 1;
    tick();
    b_start = 0;
    check("ovf_clear_on_start", b_overflow, 0);
    b_in_valid = 1; b_in_sum = 5; tick();
    b_in_valid = 0;
    check("ovf_clear_out_sum", b_out_sum, 5);
    check("ovf_clear_overflow", b_overflow, 0);
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
